frame_buffer_fill: RTL and testbench
====================================

# frame_buffer_fill

Avalon-MM burst write master that fills a contiguous region of HPS SDRAM with a constant 32-bit value: color-buffer clear, Z-buffer clear, or test patterns. It is the write-side counterpart of the frame-buffer scan-out read master. It is triggered by a one-cycle start pulse from the rasterizer or the HPS command path. It drives one of the f2h_sdram write ports (64-bit data, 29-bit word address).

## Interface
Parameters:
- BURST_LENGTH, 8: maximum beats per burst; power of two, 1..128.
- COUNT_BITS, 20: width of word_count; covers 800x480x4 bytes / 8 = 192000 words.

Ports:
- clock  in  1: system clock, 50 MHz domain.
- reset  in  1: synchronous, active-high.
- start  in  1: one-cycle request; honoured only when idle.
- base_address  in  29: first 64-bit word address; sampled on accepted start.
- word_count  in  COUNT_BITS: number of 64-bit words to write; sampled on accepted start.
- fill_value  in  32: pixel value; sampled on accepted start.
- busy  out  1: high from the cycle after an accepted start until completion.
- done  out  1: one-cycle pulse on completion.
- address  out  29: Avalon burst start address.
- burstcount  out  8: Avalon beats in the current burst.
- writedata  out  64: {fill_value, fill_value}.
- byteenable  out  8: constant 8'hFF.
- write  out  1: Avalon write request.
- waitrequest  in  1: Avalon stall.

## Operation
- States:
  - IDLE: waits for start.
  - BURST: presents beats.
- IDLE, start=1:
  - Latch base_address, word_count and fill_value.
  - If word_count=0, stay IDLE and pulse done next cycle; no write is issued.
  - Otherwise go to BURST with burstcount=min(BURST_LENGTH, remaining) and address=current address.
- BURST:
  - write=1 continuously.
  - A beat is accepted on each cycle with write && !waitrequest.
  - address and burstcount stay constant for the whole burst; writedata is constant.
- On acceptance of the last beat of a burst:
  - Advance the address by the burstcount and reduce remaining by the burstcount.
  - If remaining is now 0, go to IDLE and pulse done.
  - Otherwise load the next burst immediately, with no idle cycle.
- Final burst may be short: word_count=19, BURST_LENGTH=8 gives bursts 8, 8, 3.
- Bursts are not split on page boundaries. Callers pass a base_address aligned to BURST_LENGTH.
- start while busy: ignored, with no effect on the latched values.
- Address arithmetic wraps modulo 2^29; there is no out-of-range check.
- Reset mid-burst:
  - write, busy and done go 0 on the next edge.
  - The partial burst is abandoned. This is acceptable only because a system reset also resets the interconnect.

## Timing
- Reset values:
  - busy=0, done=0, write=0.
  - address=0, burstcount=0.
  - writedata=0, byteenable=8'hFF.
- start is sampled at edge N; write=1 with the first beat from cycle N+1.
- With waitrequest=0, throughput is one beat per cycle, including across burst boundaries.
- Completion: the last beat is accepted at edge K; done=1 and busy=0 during cycle K+1, and write=0 in that cycle.
- word_count=0: start at edge N gives done=1 during cycle N+1; busy stays 0.
- Every Avalon output is registered; no combinational path from waitrequest to any output.
- Total cycles with waitrequest=0: word_count cycles of write, plus one cycle to done.

## Structure
- Shared package sdram_pkg holds SDRAM_ADDRESS_BITS=29, SDRAM_DATA_BITS=64 and SDRAM_BURSTCOUNT_BITS=8. The scan-out reader and the rasterizer masters use the same package.
- The state enum is local to the module.
- One natural sub-module is burst_sizer: a combinational min(BURST_LENGTH, remaining), reusable by the read masters.
- Everything else is flat in frame_buffer_fill.

## Test plan
- Two full bursts, no stall:
  - Stimulus: base=0x0700_0000, count=16, fill=0x11223344, waitrequest=0.
  - Response: bursts at 0x0700_0000 then 0x0700_0008, burstcount=8 each, 16 consecutive write cycles, done 17 cycles after start.
- Short final burst:
  - Stimulus: count=19.
  - Response: burstcounts 8, 8, 3 at base, base+8, base+16; exactly 19 accepted beats; one done pulse.
- Random stall:
  - Stimulus: waitrequest random at 50%, count=19.
  - Response: address, burstcount and writedata stable while stalled; 19 accepted beats; done only after the last acceptance.
- Zero count:
  - Stimulus: count=0.
  - Response: write never asserted; done=1 exactly one cycle after start; busy stays 0.
- Start while busy, then reset mid-burst:
  - Stimulus: second start with count=4 mid-fill, then reset asserted at beat 5 of a 16-word fill.
  - Response: the second start is ignored. After reset, write=0, busy=0 and done=0 on the next cycle, and a subsequent start works normally.
- Data pattern:
  - Stimulus: fill=0x00FF00FF.
  - Response: writedata=0x00FF00FF00FF00FF and byteenable=8'hFF on every beat.

Source files
------------

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared f2h_sdram port geometry for the read and write masters
package sdram_pkg;
   localparam int SDRAM_ADDRESS_BITS    = 29;
   localparam int SDRAM_DATA_BITS       = 64;
   localparam int SDRAM_BURSTCOUNT_BITS = 8;
endpackage

// File: rtl/burst_sizer.sv
// rtl/burst_sizer.sv - length of the next burst: min(BURST_LENGTH, remaining)
module burst_sizer
   import sdram_pkg::*;
#(
   parameter int BURST_LENGTH = 8,
   parameter int COUNT_BITS   = 20
) (
   input  logic [COUNT_BITS-1:0]            remaining,
   output logic [SDRAM_BURSTCOUNT_BITS-1:0] burstcount
);

   always_comb begin
      if (remaining >= COUNT_BITS'(BURST_LENGTH))
         burstcount = SDRAM_BURSTCOUNT_BITS'(BURST_LENGTH);
      else
         burstcount = SDRAM_BURSTCOUNT_BITS'(remaining);
   end

endmodule

// File: rtl/frame_buffer_fill.sv
// rtl/frame_buffer_fill.sv - Avalon-MM burst write master filling SDRAM with a constant
module frame_buffer_fill
   import sdram_pkg::*;
#(
   parameter int BURST_LENGTH = 8,
   parameter int COUNT_BITS   = 20
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               start,
   input  logic [SDRAM_ADDRESS_BITS-1:0]      base_address,
   input  logic [COUNT_BITS-1:0]              word_count,
   input  logic [31:0]                        fill_value,
   output logic                               busy,
   output logic                               done,
   output logic [SDRAM_ADDRESS_BITS-1:0]      address,
   output logic [SDRAM_BURSTCOUNT_BITS-1:0]   burstcount,
   output logic [SDRAM_DATA_BITS-1:0]         writedata,
   output logic [SDRAM_DATA_BITS/8-1:0]       byteenable,
   output logic                               write,
   input  logic                               waitrequest
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   logic [0:0]                       state;
   logic [COUNT_BITS-1:0]            remaining;
   logic [COUNT_BITS-1:0]            remaining_after;
   logic [COUNT_BITS-1:0]            sizer_in;
   logic [SDRAM_BURSTCOUNT_BITS-1:0] next_burstcount;
   logic [SDRAM_BURSTCOUNT_BITS-1:0] beat;
   logic                             beat_accepted;
   logic                             last_beat;

   assign byteenable      = '1;
   assign beat_accepted   = write && !waitrequest;
   assign last_beat       = beat_accepted && (beat == burstcount - 1'b1);
   assign remaining_after = remaining - COUNT_BITS'(burstcount);

   // One sizer serves both the first burst (from word_count) and every follow-on burst.
   assign sizer_in = (state == IDLE) ? word_count : remaining_after;

   burst_sizer #(
      .BURST_LENGTH (BURST_LENGTH),
      .COUNT_BITS   (COUNT_BITS)
   ) u_burst_sizer (
      .remaining  (sizer_in),
      .burstcount (next_burstcount)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         remaining  <= '0;
         beat       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         write      <= 1'b0;
         address    <= '0;
         burstcount <= '0;
         writedata  <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               writedata <= {fill_value, fill_value};
               remaining <= word_count;
               address   <= base_address;
               beat      <= '0;
               if (word_count == '0) begin
                  done <= 1'b1;
               end else begin
                  state      <= BURST;
                  busy       <= 1'b1;
                  write      <= 1'b1;
                  burstcount <= next_burstcount;
               end
            end
         end else if (beat_accepted) begin
            if (last_beat) begin
               beat      <= '0;
               remaining <= remaining_after;
               address   <= address + SDRAM_ADDRESS_BITS'(burstcount);
               if (remaining_after == '0) begin
                  state <= IDLE;
                  write <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  burstcount <= next_burstcount;
               end
            end else begin
               beat <= beat + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_buffer_fill.sv
// tb/tb_frame_buffer_fill.sv - directed bench for frame_buffer_fill
module tb_frame_buffer_fill;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [28:0] base_address;
   logic [19:0] word_count;
   logic [31:0] fill_value;
   logic        busy;
   logic        done;
   logic [28:0] address;
   logic [7:0]  burstcount;
   logic [63:0] writedata;
   logic [7:0]  byteenable;
   logic        write;
   logic        waitrequest;

   always #10 clock = ~clock;

   frame_buffer_fill #(
      .BURST_LENGTH (8),
      .COUNT_BITS   (20)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .base_address (base_address),
      .word_count   (word_count),
      .fill_value   (fill_value),
      .busy         (busy),
      .done         (done),
      .address      (address),
      .burstcount   (burstcount),
      .writedata    (writedata),
      .byteenable   (byteenable),
      .write        (write),
      .waitrequest  (waitrequest)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   logic [28:0] b_addr[$];
   logic [7:0]  b_len[$];
   int beats, write_cycles, done_cycle, done_count, last_accept;
   int stable_err, data_err, busy_seen, done_dirty;

   // Cycle c is the c-th cycle after the edge that accepted start.
   task automatic run_fill(input logic [28:0] base, input logic [19:0] count,
                           input logic [31:0] fill, input logic [63:0] exp_data, input bit stall);
      int beat_in;
      bit in_burst;
      logic [28:0] pa;
      logic [7:0]  pb;
      b_addr.delete();
      b_len.delete();
      beats = 0; write_cycles = 0; done_cycle = 0; done_count = 0; last_accept = 0;
      stable_err = 0; data_err = 0; busy_seen = 0; done_dirty = 0;
      beat_in = 0; in_burst = 0; pa = '0; pb = '0;
      @(negedge clock);
      start = 1'b1; base_address = base; word_count = count; fill_value = fill;
      @(posedge clock);
      for (int c = 1; c <= 400; c++) begin
         @(negedge clock);
         start = 1'b0;
         if (busy) busy_seen++;
         if (done) begin
            done_count++;
            if (done_cycle == 0) done_cycle = c;
            if (write || busy) done_dirty++;
         end
         if (write) begin
            write_cycles++;
            if (writedata !== exp_data || byteenable !== 8'hFF) data_err++;
            if (!in_burst) begin
               b_addr.push_back(address);
               b_len.push_back(burstcount);
               in_burst = 1; beat_in = 0;
            end else if (address !== pa || burstcount !== pb) begin
               stable_err++;
            end
            pa = address; pb = burstcount;
         end
         waitrequest = stall ? 1'($urandom_range(0, 1)) : 1'b0;
         if (write && !waitrequest) begin
            beats++; beat_in++; last_accept = c;
            if (beat_in == int'(burstcount)) in_burst = 0;
         end
         if (done_cycle != 0 && c >= done_cycle + 3) break;
      end
      waitrequest = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; waitrequest = 1'b0;
      base_address = '0; word_count = '0; fill_value = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_write", 64'(write), 64'd0);
      check("reset_address", 64'(address), 64'd0);
      check("reset_burstcount", 64'(burstcount), 64'd0);
      check("reset_writedata", writedata, 64'd0);
      check("reset_byteenable", 64'(byteenable), 64'hFF);
      reset = 1'b0;

      // two full bursts, no stall
      run_fill(29'h0700_0000, 20'd16, 32'h1122_3344, 64'h1122_3344_1122_3344, 1'b0);
      check("t1_bursts", 64'(b_addr.size()), 64'd2);
      check("t1_addr0", 64'(b_addr[0]), 64'h0700_0000);
      check("t1_addr1", 64'(b_addr[1]), 64'h0700_0008);
      check("t1_len0", 64'(b_len[0]), 64'd8);
      check("t1_len1", 64'(b_len[1]), 64'd8);
      check("t1_write_cycles", 64'(write_cycles), 64'd16);
      check("t1_done_cycle", 64'(done_cycle), 64'd17);
      check("t1_done_pulses", 64'(done_count), 64'd1);
      check("t1_done_clean", 64'(done_dirty), 64'd0);
      check("t1_data", 64'(data_err), 64'd0);

      // short final burst
      run_fill(29'h0000_0100, 20'd19, 32'hCAFE_F00D, 64'hCAFE_F00D_CAFE_F00D, 1'b0);
      check("t2_bursts", 64'(b_addr.size()), 64'd3);
      check("t2_addr2", 64'(b_addr[2]), 64'h0000_0110);
      check("t2_len1", 64'(b_len[1]), 64'd8);
      check("t2_len2", 64'(b_len[2]), 64'd3);
      check("t2_beats", 64'(beats), 64'd19);
      check("t2_done_cycle", 64'(done_cycle), 64'd20);
      check("t2_done_pulses", 64'(done_count), 64'd1);

      // random stall
      run_fill(29'h0000_2000, 20'd19, 32'hDEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
      check("t3_beats", 64'(beats), 64'd19);
      check("t3_stable", 64'(stable_err), 64'd0);
      check("t3_data", 64'(data_err), 64'd0);
      check("t3_len2", 64'(b_len[2]), 64'd3);
      check("t3_addr2", 64'(b_addr[2]), 64'h0000_2010);
      check("t3_done_after_last", 64'(done_cycle - last_accept), 64'd1);
      check("t3_done_pulses", 64'(done_count), 64'd1);

      // zero count
      run_fill(29'h0000_4000, 20'd0, 32'h1234_5678, 64'h1234_5678_1234_5678, 1'b0);
      check("t4_write_cycles", 64'(write_cycles), 64'd0);
      check("t4_done_cycle", 64'(done_cycle), 64'd1);
      check("t4_done_pulses", 64'(done_count), 64'd1);
      check("t4_busy_seen", 64'(busy_seen), 64'd0);

      // start while busy, then reset during beat 5
      @(negedge clock);
      start = 1'b1; base_address = 29'h0000_0200; word_count = 20'd16; fill_value = 32'hA5A5_5A5A;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      start = 1'b1; base_address = 29'h0000_9000; word_count = 20'd4; fill_value = 32'h0BAD_0BAD;
      @(negedge clock);
      start = 1'b0;
      check("t5_addr_kept", 64'(address), 64'h0000_0200);
      check("t5_len_kept", 64'(burstcount), 64'd8);
      check("t5_data_kept", writedata, 64'hA5A5_5A5A_A5A5_5A5A);
      @(negedge clock);
      check("t5_busy_mid", 64'(busy), 64'd1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("t5_rst_write", 64'(write), 64'd0);
      check("t5_rst_busy", 64'(busy), 64'd0);
      check("t5_rst_done", 64'(done), 64'd0);
      reset = 1'b0;
      run_fill(29'h0000_0300, 20'd3, 32'h7777_8888, 64'h7777_8888_7777_8888, 1'b0);
      check("t5_after_bursts", 64'(b_addr.size()), 64'd1);
      check("t5_after_addr", 64'(b_addr[0]), 64'h0000_0300);
      check("t5_after_len", 64'(b_len[0]), 64'd3);
      check("t5_after_done", 64'(done_cycle), 64'd4);

      // data pattern
      run_fill(29'h0000_0400, 20'd5, 32'h00FF_00FF, 64'h00FF_00FF_00FF_00FF, 1'b0);
      check("t6_data", 64'(data_err), 64'd0);
      check("t6_writedata", writedata, 64'h00FF_00FF_00FF_00FF);
      check("t6_byteenable", 64'(byteenable), 64'hFF);
      check("t6_beats", 64'(beats), 64'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
